// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scans a mux sel across all inputs and assembles the sampled bits into a word
module mux_scan_ctrl #(
  parameter int SEL_W  = 2,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cont,
  input  logic                    mux_out,
  output logic [SEL_W-1:0]        sel,
  output logic                    busy,
  output logic                    done,
  output logic [(2**SEL_W)-1:0]   data
);

  localparam int N     = 2 ** SEL_W;
  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N - 1);
  localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       shadow_q, shadow_d;
  logic [N-1:0]       data_q, data_d;
  logic               done_q, done_d;

  // State, index, settle counter, partial word and published word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  // Next-state: count down the settle time, sample on expiry, publish the word after the last index.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SCAN;
          sel_d    = '0;
          cnt_d    = RELOAD;
          shadow_d = '0;
        end
      end

      ST_SCAN: begin
        if (cnt_q == CNT_ONE) begin
          shadow_d[sel_q] = mux_out;
          cnt_d           = RELOAD;
          if (sel_q != SEL_MAX) begin
            sel_d = sel_q + SEL_ONE;
          end else begin
            // Publish the whole word at once; the partial word restarts empty.
            data_d   = shadow_d;
            done_d   = 1'b1;
            sel_d    = '0;
            shadow_d = '0;
            if (!cont) begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sel  = sel_q;
  assign busy = (state_q == ST_SCAN);
  assign done = done_q;
  assign data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with SETTLE=1 and SETTLE=3
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v  [2];
  logic       cont_v   [2];
  logic       mo       [2];
  logic       busy_v   [2];
  logic       done_v   [2];
  logic [1:0] sel_v    [2];
  logic [3:0] in_v     [2];
  logic [3:0] data_v   [2];
  logic [3:0] exp_data [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural 4:1 muxes feeding each sequencer.
  assign mo[0] = in_v[0][sel_v[0]];
  assign mo[1] = in_v[1][sel_v[1]];

  mux_scan_ctrl #(.SEL_W(2), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .cont(cont_v[0]), .mux_out(mo[0]),
    .sel(sel_v[0]), .busy(busy_v[0]), .done(done_v[0]), .data(data_v[0])
  );

  mux_scan_ctrl #(.SEL_W(2), .SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .cont(cont_v[1]), .mux_out(mo[1]),
    .sel(sel_v[1]), .busy(busy_v[1]), .done(done_v[1]), .data(data_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic launch(input int d);
    start_v[d] = 1'b1;
    tick();
  endtask

  // Entered just after the scan's start edge; returns just after its completion edge.
  task automatic body(input int d, input logic [3:0] val, input logic cont_final,
                      input logic hold_start, input string tag);
    int s;
    s = settle_of(d);
    in_v[d] = val;
    if (!hold_start) start_v[d] = 1'b0;
    for (int k = 0; k < 4 * s; k++) begin
      if (k == 1) cont_v[d] = cont_final;
      chk({tag, ".sel"}, 32'(sel_v[d]), 32'(k / s));
      chk({tag, ".busy"}, 32'(busy_v[d]), 32'd1);
      if (k > 0) chk({tag, ".done_low"}, 32'(done_v[d]), 32'd0);
      chk({tag, ".data_hold"}, 32'(data_v[d]), 32'(exp_data[d]));
      tick();
    end
    exp_data[d] = val;
    chk({tag, ".done"}, 32'(done_v[d]), 32'd1);
    chk({tag, ".data"}, 32'(data_v[d]), 32'(exp_data[d]));
    chk({tag, ".busy_end"}, 32'(busy_v[d]), 32'(cont_final));
    chk({tag, ".sel_end"}, 32'(sel_v[d]), 32'd0);
  endtask

  task automatic idle_chk(input int d, input string tag);
    chk({tag, ".idle_busy"}, 32'(busy_v[d]), 32'd0);
    chk({tag, ".idle_done"}, 32'(done_v[d]), 32'd0);
    chk({tag, ".idle_sel"}, 32'(sel_v[d]), 32'd0);
    chk({tag, ".idle_data"}, 32'(data_v[d]), 32'(exp_data[d]));
  endtask

  task automatic reset_chk(input int d, input string tag);
    chk({tag, ".rst_sel"}, 32'(sel_v[d]), 32'd0);
    chk({tag, ".rst_busy"}, 32'(busy_v[d]), 32'd0);
    chk({tag, ".rst_done"}, 32'(done_v[d]), 32'd0);
    chk({tag, ".rst_data"}, 32'(data_v[d]), 32'd0);
  endtask

  initial begin
    logic [3:0] v;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_v[d]  = 1'b0;
      cont_v[d]   = 1'b0;
      in_v[d]     = 4'h0;
      exp_data[d] = 4'h0;
    end

    // Asynchronous reset with no clock edge yet.
    #2 rst = 1'b1;
    #1;
    reset_chk(0, "por0");
    reset_chk(1, "por1");
    tick();
    tick();
    rst = 1'b0;
    tick();
    idle_chk(0, "init0");

    // Basic scans at both settle times.
    launch(0);
    body(0, 4'b1101, 1'b0, 1'b0, "basic_s1");
    tick();
    idle_chk(0, "basic_s1");

    launch(1);
    body(1, 4'b0110, 1'b0, 1'b0, "basic_s3");
    tick();
    idle_chk(1, "basic_s3");

    // Random input patterns.
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 2; d++) begin
        v = 4'($urandom_range(0, 15));
        launch(d);
        body(d, v, 1'b0, 1'b0, "rand");
        tick();
        idle_chk(d, "rand");
      end
    end

    // Continuous mode, cont dropped during the second scan.
    cont_v[0] = 1'b1;
    launch(0);
    body(0, 4'b1010, 1'b1, 1'b0, "cont1");
    body(0, 4'b0101, 1'b0, 1'b0, "cont2");
    tick();
    idle_chk(0, "cont_end");

    // start held high: no mid-scan restart, restart at the edge after completion.
    start_v[0] = 1'b1;
    tick();
    v = 4'($urandom_range(0, 15));
    body(0, v, 1'b0, 1'b1, "hold1");
    tick();
    v = 4'($urandom_range(0, 15));
    body(0, v, 1'b0, 1'b0, "hold2");
    tick();
    idle_chk(0, "hold_end");

    // Reset mid-scan at sel=2 with data previously 1111.
    launch(0);
    body(0, 4'b1111, 1'b0, 1'b0, "pre_rst");
    tick();
    in_v[0] = 4'b0000;
    launch(0);
    start_v[0] = 1'b0;
    tick();
    tick();
    chk("mid.sel_before", 32'(sel_v[0]), 32'd2);
    #2 rst = 1'b1;
    #1;
    exp_data[0] = 4'h0;
    exp_data[1] = 4'h0;
    reset_chk(0, "mid0");
    reset_chk(1, "mid1");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid.no_done", 32'(done_v[0]), 32'd0);
    end
    rst = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      v = 4'($urandom_range(0, 15));
      launch(d);
      body(d, v, 1'b0, 1'b0, "post_rst");
      tick();
      idle_chk(d, "post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
